lcd_frame_refresher: RTL and testbench
======================================

# lcd_frame_refresher

Parametrised character-LCD controller that owns a ROWS×COLS character buffer and keeps an HD44780-class display refreshed from it. After reset it runs the power-on wait and initialisation command sequence. It then loops forever: it sets the DDRAM address at the start of each row and streams every buffered character. All output goes as RS/RW/data words over a valid/ready handshake to the downstream 4-bit nibble interface. Host logic updates the display by writing the buffer; it never sequences commands itself.

## Interface
Parameters:
- COLS, 16: characters per row; legal range 1..40.
- ROWS, 2: display rows; legal values 1, 2, 4.
- POWERON_WAIT, 750000: clock cycles to wait after reset release before the first command.
- CLEAR_WAIT, 82000: clock cycles to wait after the clear-display command is accepted.
- AW, $clog2(ROWS*COLS): buffer address width.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  host buffer write strobe.
- wr_addr  in  AW  buffer index, row*COLS+col. Values ≥ ROWS*COLS are ignored.
- wr_data  in  8  character code.
- restart  in  1  request to re-run the initialisation sequence.
- cmd_valid  out  1  word on cmd_rs/cmd_rw/cmd_data is offered.
- cmd_ready  in  1  downstream interface accepts the word.
- cmd_rs  out  1  0 = command, 1 = character data.
- cmd_rw  out  1  always 0 (write).
- cmd_data  out  8  command or character byte.
- init_done  out  1  high once the initialisation sequence has completed.
- frame_done  out  1  one-cycle pulse when the last character of a frame is accepted.

## Operation
- Transfer rule: a word transfers on a rising edge where cmd_valid and cmd_ready are both 1.
  - Once cmd_valid is raised, cmd_rs, cmd_rw and cmd_data hold stable until the transfer.
  - cmd_valid never drops without a transfer.
- States: PWR_WAIT → INIT → CLR_WAIT → SET_ADDR → FETCH → PRESENT → (SET_ADDR | FETCH).
- PWR_WAIT: counts POWERON_WAIT cycles with cmd_valid=0.
- INIT: offers four commands in order, each with rs=0: 0x28, 0x06, 0x0C, 0x01.
- CLR_WAIT: entered after 0x01 transfers. Counts CLEAR_WAIT cycles, then sets init_done=1 and row=col=0.
- SET_ADDR: offers command 0x80|base(row).
  - base(row) = (row%2)*0x40 + (row/2)*COLS, giving 0x00, 0x40, 0x14, 0x54 for COLS=20.
- FETCH: one cycle. Registers buf[row*COLS+col] into the payload register.
- PRESENT: offers that byte with rs=1. On transfer:
  - If col<COLS-1: col++, go to FETCH.
  - Else: col=0 and row wraps to 0 after ROWS-1.
    - Not the last row: go to SET_ADDR.
    - Last row: pulse frame_done, go to SET_ADDR.
- Buffer: ROWS*COLS bytes, single write port.
  - A write takes effect on the edge where wr_en=1.
  - The payload is captured in FETCH, so a write to a word already being offered does not alter it; the new value appears next frame.
  - A write in the same cycle as the FETCH of that address returns the old value.
  - Buffer contents are power-up initialised to 0x20 (space) and are unaffected by reset.
- restart: sampled every cycle and latched into a pending flag.
  - The flag is acted on when cmd_valid=0, or on the edge of a transfer.
  - Action: clear the flag, clear init_done, go to INIT. PWR_WAIT is skipped.
  - restart during PWR_WAIT, INIT or CLR_WAIT is ignored.
- Reset: asynchronous. State = PWR_WAIT, counters, row and col = 0, pending restart cleared.

## Timing
- Reset values:
  - cmd_valid=0, cmd_rs=0, cmd_rw=0, cmd_data=0x00.
  - init_done=0, frame_done=0.
- First cmd_valid rises POWERON_WAIT+1 cycles after reset deasserts.
- With cmd_ready tied 1:
  - Each INIT and SET_ADDR word takes 1 cycle.
  - Each character takes 2 cycles (FETCH + PRESENT).
  - One frame takes ROWS*(1+2*COLS) cycles; frame_done repeats at that period.
- init_done rises CLEAR_WAIT cycles after the 0x01 transfer edge.
  - The first SET_ADDR word (0x80) is offered in the same cycle.
- Outputs are registered; there is no combinational path from cmd_ready to cmd_valid or the payload.

## Test plan
- Reset, POWERON_WAIT=10, CLEAR_WAIT=5, cmd_ready=1 → cmd_valid first high in cycle 11. Words are 0x28, 0x06, 0x0C, 0x01 (rs=0). init_done rises 5 cycles after 0x01, then 0x80 is offered.
- COLS=4, ROWS=2, buffer "ABCDEFGH" → each frame is 0x80, 41, 42, 43, 44, 0xC0, 45, 46, 47, 48. Characters have rs=1. frame_done is 1 cycle wide with period 18.
- cmd_ready toggled pseudo-randomly → while cmd_valid=1 and no transfer, the payload never changes. No word is lost or duplicated versus the reference sequence.
- Write 0x5A to index 2 while char index 2 is held (cmd_ready=0) → held byte stays the old value. The next frame shows 0x5A. A write to index 8 (COLS=4, ROWS=2) is ignored.
- COLS=20, ROWS=4 → address commands 0x80, 0xC0, 0x94, 0xD4 in row order.
- restart pulsed mid-row with cmd_ready=0 → held word still completes. Then init_done=0 and 0x28..0x01 re-issue without POWERON_WAIT. Async reset asserted mid-INIT → outputs return to reset values immediately.

Source files
------------

// File: rtl/lcd_frame_refresher.sv
// rtl/lcd_frame_refresher.sv - HD44780-class character LCD controller refreshing the display from a ROWS x COLS buffer
// Runs power-on wait and init commands, then streams address commands and characters forever.
module lcd_frame_refresher #(
    parameter int COLS         = 16,
    parameter int ROWS         = 2,
    parameter int POWERON_WAIT = 750000,
    parameter int CLEAR_WAIT   = 82000,
    parameter int AW           = $clog2(ROWS * COLS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          restart,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic          cmd_rs,
    output logic          cmd_rw,
    output logic [7:0]    cmd_data,
    output logic          init_done,
    output logic          frame_done
);
    localparam int DEPTH = ROWS * COLS;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        CLR_WAIT,
        SET_ADDR,
        FETCH,
        PRESENT
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [1:0]    init_idx_q, init_idx_d;
    logic [1:0]    row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          valid_q, valid_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          init_done_q, init_done_d;
    logic          frame_done_q, frame_done_d;
    logic          pend_q, pend_d;
    logic          xfer;

    // Stored XOR 0x20 so that zeroed power-up RAM reads back as spaces.
    logic [7:0] mem_q [0:(1<<AW)-1];

    always_ff @(posedge clock) begin
        if (wr_en && ({{(32-AW){1'b0}}, wr_addr} < 32'(DEPTH))) begin
            mem_q[wr_addr] <= wr_data ^ 8'h20;
        end
    end

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h28;
            2'd1:    return 8'h06;
            2'd2:    return 8'h0C;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [7:0] addr_cmd(input logic [1:0] row);
        logic [7:0] base;
        base = row[0] ? 8'h40 : 8'h00;
        if (row[1]) begin
            base = base + 8'(COLS);
        end
        return 8'h80 | base;
    endfunction

    assign xfer = valid_q && cmd_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        init_idx_d   = init_idx_q;
        row_d        = row_q;
        col_d        = col_q;
        ptr_d        = ptr_q;
        valid_d      = valid_q;
        rs_d         = rs_q;
        data_d       = data_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        pend_d       = 1'b0;

        case (state_q)
            PWR_WAIT: begin
                if (cnt_q == 32'(POWERON_WAIT)) begin
                    state_d    = INIT;
                    cnt_d      = 32'd0;
                    init_idx_d = 2'd0;
                    valid_d    = 1'b1;
                    rs_d       = 1'b0;
                    data_d     = init_cmd(2'd0);
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            INIT: begin
                if (xfer) begin
                    if (init_idx_q == 2'd3) begin
                        state_d = CLR_WAIT;
                        valid_d = 1'b0;
                        cnt_d   = 32'd0;
                    end else begin
                        init_idx_d = init_idx_q + 2'd1;
                        data_d     = init_cmd(init_idx_q + 2'd1);
                    end
                end
            end
            CLR_WAIT: begin
                if (cnt_q + 32'd1 >= 32'(CLEAR_WAIT)) begin
                    state_d     = SET_ADDR;
                    cnt_d       = 32'd0;
                    init_done_d = 1'b1;
                    row_d       = 2'd0;
                    col_d       = '0;
                    ptr_d       = '0;
                    valid_d     = 1'b1;
                    rs_d        = 1'b0;
                    data_d      = addr_cmd(2'd0);
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            SET_ADDR: begin
                if (xfer) begin
                    state_d = FETCH;
                    valid_d = 1'b0;
                end
            end
            FETCH: begin
                state_d = PRESENT;
                valid_d = 1'b1;
                rs_d    = 1'b1;
                data_d  = mem_q[ptr_q] ^ 8'h20;
            end
            PRESENT: begin
                if (xfer) begin
                    if (col_q != CW'(COLS - 1)) begin
                        state_d = FETCH;
                        valid_d = 1'b0;
                        col_d   = col_q + CW'(1);
                        ptr_d   = ptr_q + AW'(1);
                    end else begin
                        state_d = SET_ADDR;
                        col_d   = '0;
                        if (row_q == 2'(ROWS - 1)) begin
                            row_d        = 2'd0;
                            ptr_d        = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            row_d = row_q + 2'd1;
                            ptr_d = ptr_q + AW'(1);
                        end
                        valid_d = 1'b1;
                        rs_d    = 1'b0;
                        data_d  = addr_cmd(row_d);
                    end
                end
            end
            default: begin
                state_d = PWR_WAIT;
                valid_d = 1'b0;
            end
        endcase

        // A pending restart only pre-empts the refresh loop, and never while a word is mid-offer.
        if (state_q == SET_ADDR || state_q == FETCH || state_q == PRESENT) begin
            pend_d = pend_q | restart;
            if (pend_q && (!valid_q || xfer)) begin
                pend_d      = 1'b0;
                init_done_d = 1'b0;
                state_d     = INIT;
                cnt_d       = 32'd0;
                init_idx_d  = 2'd0;
                valid_d     = 1'b1;
                rs_d        = 1'b0;
                data_d      = init_cmd(2'd0);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= PWR_WAIT;
            cnt_q        <= 32'd0;
            init_idx_q   <= 2'd0;
            row_q        <= 2'd0;
            col_q        <= '0;
            ptr_q        <= '0;
            valid_q      <= 1'b0;
            rs_q         <= 1'b0;
            data_q       <= 8'h00;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            init_idx_q   <= init_idx_d;
            row_q        <= row_d;
            col_q        <= col_d;
            ptr_q        <= ptr_d;
            valid_q      <= valid_d;
            rs_q         <= rs_d;
            data_q       <= data_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
            pend_q       <= pend_d;
        end
    end

    assign cmd_valid  = valid_q;
    assign cmd_rs     = rs_q;
    assign cmd_rw     = 1'b0;
    assign cmd_data   = data_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_frame_refresher.sv
// tb/tb_lcd_frame_refresher.sv - randomized self-checking bench for lcd_frame_refresher
module tb_lcd_frame_refresher;
    localparam int COLS = 4;
    localparam int ROWS = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [7:0] wr_data = 8'd0;
    logic       restart = 1'b0;
    logic       cmd_ready = 1'b1;
    logic       cmd_valid, cmd_rs, cmd_rw, init_done, frame_done;
    logic [7:0] cmd_data;
    logic       v4, rs4, rw4, id4, fd4;
    logic [7:0] d4;

    always #5 clock = ~clock;

    lcd_frame_refresher #(
        .COLS(COLS), .ROWS(ROWS), .POWERON_WAIT(10), .CLEAR_WAIT(5), .AW(4)
    ) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .restart(restart), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rs(cmd_rs),
        .cmd_rw(cmd_rw), .cmd_data(cmd_data), .init_done(init_done), .frame_done(frame_done)
    );

    lcd_frame_refresher #(
        .COLS(20), .ROWS(4), .POWERON_WAIT(10), .CLEAR_WAIT(5)
    ) dut4 (
        .clock(clock), .reset(reset), .wr_en(1'b0), .wr_addr(7'd0), .wr_data(8'd0),
        .restart(1'b0), .cmd_valid(v4), .cmd_ready(1'b1), .cmd_rs(rs4),
        .cmd_rw(rw4), .cmd_data(d4), .init_done(id4), .frame_done(fd4)
    );

    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         n;
    int         t0;
    bit         rand_ready = 1'b0;
    logic [7:0] old;
    logic [7:0] model [0:7];
    logic [8:0] obs_q [$];
    logic [8:0] exp_q [$];
    logic [7:0] obs4_q [$];
    int         fd_cyc [$];
    logic       prev_hold = 1'b0;
    logic [8:0] prev_word = 9'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Observes every transfer and the hold-stable rule on the negative edge.
    always @(negedge clock) begin
        if (reset) begin
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 32'(cmd_valid), 32'd1);
                chk("hold_payload", 32'({cmd_rs, cmd_data}), 32'(prev_word));
            end
            if (cmd_valid && cmd_ready) begin
                obs_q.push_back({cmd_rs, cmd_data});
                chk("rw_zero", 32'(cmd_rw), 32'd0);
            end
            if (frame_done) fd_cyc.push_back(cyc);
            if (v4 && !rs4) obs4_q.push_back(d4);
            prev_hold <= cmd_valid && !cmd_ready;
            prev_word <= {cmd_rs, cmd_data};
        end
    end

    function automatic logic [7:0] base_addr(input int r, input int cols);
        return 8'((r % 2) * 64 + (r / 2) * cols);
    endfunction

    task automatic push_init();
        logic [7:0] c [4];
        c = '{8'h28, 8'h06, 8'h0C, 8'h01};
        foreach (c[i]) exp_q.push_back({1'b0, c[i]});
    endtask

    task automatic push_frame();
        for (int r = 0; r < ROWS; r++) begin
            exp_q.push_back({1'b0, 8'h80 | base_addr(r, COLS)});
            for (int c = 0; c < COLS; c++) exp_q.push_back({1'b1, model[r * COLS + c]});
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (rand_ready) cmd_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_fd(input string tag);
        int k;
        k = 0;
        step();
        while (!frame_done && k < 400) begin
            step();
            k++;
        end
        chk(tag, 32'(frame_done), 32'd1);
    endtask

    task automatic compare_stream(input string tag);
        chk({tag, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk(tag, 32'(obs_q[i]), 32'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) model[i] = 8'h41 + 8'(i);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", 32'(cmd_valid), 32'd0);
        chk("rst_rs", 32'(cmd_rs), 32'd0);
        chk("rst_rw", 32'(cmd_rw), 32'd0);
        chk("rst_data", 32'(cmd_data), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);

        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = model[i];
            @(posedge clock);
            #1;
        end
        wr_en = 1'b0;
        reset = 1'b0;
        push_init();

        n = 0;
        while (!cmd_valid && n < 100) begin step(); n++; end
        chk("first_valid_cycle", 32'(cyc), 32'd11);
        chk("first_word", 32'({cmd_rs, cmd_data}), 32'h028);

        n = 0;
        while (!init_done && n < 100) begin step(); n++; end
        chk("init_done_cycle", 32'(cyc), 32'd20);
        chk("first_addr", 32'({cmd_valid, cmd_rs, cmd_data}), 32'h280);

        push_frame();
        push_frame();
        wait_fd("fd1");
        wait_fd("fd2");
        compare_stream("frames_abcd");
        push_frame();
        step();
        chk("fd_count", 32'(fd_cyc.size()), 32'd2);
        if (fd_cyc.size() >= 2) begin
            chk("fd_first_cycle", 32'(fd_cyc[0]), 32'd38);
            chk("fd_period", 32'(fd_cyc[1] - fd_cyc[0]), 32'd18);
        end

        rand_ready = 1'b1;
        wait_fd("fd3");
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 8; i++) begin
                wr_en = 1'b1; wr_addr = 4'(i); wr_data = 8'($urandom_range(32, 126));
                model[i] = wr_data;
                step();
            end
            wr_en = 1'b0;
            push_frame();
            wait_fd("fd_rand");
        end
        compare_stream("rand_ready");

        rand_ready = 1'b0;
        cmd_ready = 1'b1;
        repeat (6) step();
        old = model[2];
        chk("held_word", 32'({cmd_valid, cmd_rs, cmd_data}), 32'({2'b11, old}));
        cmd_ready = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h5A;
        step();
        wr_addr = 4'd8; wr_data = 8'h77;
        step();
        wr_en = 1'b0;
        repeat (3) step();
        chk("held_after_write", 32'({cmd_valid, cmd_rs, cmd_data}), 32'({2'b11, old}));
        cmd_ready = 1'b1;
        push_frame();
        model[2] = 8'h5A;
        wait_fd("fd_hold");
        repeat (7) step();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h33;
        step();
        wr_en = 1'b0;
        push_frame();
        model[3] = 8'h33;
        wait_fd("fd_fetch_race");
        push_frame();
        wait_fd("fd_after_race");
        compare_stream("buffer_writes");

        repeat (4) step();
        cmd_ready = 1'b0;
        restart = 1'b1;
        step();
        restart = 1'b0;
        repeat (2) step();
        chk("restart_held", 32'({cmd_valid, cmd_rs, cmd_data}), 32'({2'b11, model[1]}));
        chk("restart_init_kept", 32'(init_done), 32'd1);
        cmd_ready = 1'b1;
        step();
        chk("restart_first_cmd", 32'({cmd_valid, cmd_rs, cmd_data}), 32'h228);
        chk("restart_init_clr", 32'(init_done), 32'd0);
        t0 = cyc;
        exp_q.push_back({1'b0, 8'h80});
        exp_q.push_back({1'b1, model[0]});
        exp_q.push_back({1'b1, model[1]});
        push_init();
        n = 0;
        while (!init_done && n < 100) begin step(); n++; end
        chk("restart_init_time", 32'(cyc - t0), 32'd9);
        chk("restart_addr", 32'({cmd_valid, cmd_rs, cmd_data}), 32'h280);
        push_frame();
        wait_fd("fd_restart");
        compare_stream("restart");

        chk("cols20_count", 32'(obs4_q.size() >= 8), 32'd1);
        for (int i = 0; i < 8 && i < obs4_q.size(); i++) begin
            if (i < 4) chk("cols20_init", 32'(obs4_q[i]), (i == 0) ? 32'h28 : (i == 1) ? 32'h06 : (i == 2) ? 32'h0C : 32'h01);
            else       chk("cols20_addr", 32'(obs4_q[i]), 32'(8'h80 | base_addr(i - 4, 20)));
        end

        restart = 1'b1;
        step();
        restart = 1'b0;
        n = 0;
        while (!(cmd_valid && !cmd_rs && cmd_data == 8'h06) && n < 20) begin step(); n++; end
        chk("midinit_reached", 32'({cmd_valid, cmd_rs, cmd_data}), 32'h206);
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(cmd_valid), 32'd0);
        chk("async_rst_rs", 32'(cmd_rs), 32'd0);
        chk("async_rst_data", 32'(cmd_data), 32'd0);
        chk("async_rst_init_done", 32'(init_done), 32'd0);
        chk("async_rst_frame_done", 32'(frame_done), 32'd0);
        chk("async_rst_dut4", 32'({v4, rw4, id4, fd4}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
